// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes and types for the register-file writeback slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int NREG = 16;
   localparam int XLEN = 32;
   localparam int IDXW = $clog2(NREG);

   typedef logic [IDXW-1:0] reg_idx_t;
   typedef logic [XLEN-1:0] xword_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t rd;
      xword_t   data;
   } wb_req_t;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_t;

endpackage

`default_nettype wire

// File: rtl/wb_skid.sv
// ============================================================================
// Module   : wb_skid
// Purpose  : One-entry skid buffer holding an ALU result that lost arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_skid
   import regfile_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_capture,
   input  logic            i_drain,
   input  logic [IDXW-1:0] i_rd,
   input  logic [XLEN-1:0] i_data,
   output logic            o_full,
   output logic [IDXW-1:0] o_rd,
   output logic [XLEN-1:0] o_data
);

   logic            r_full;
   logic [IDXW-1:0] r_rd;
   logic [XLEN-1:0] r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
      end else if (i_capture) begin
         r_full <= 1'b1;
         r_rd   <= i_rd;
         r_data <= i_data;
      end else if (i_drain) begin
         r_full <= 1'b0;
      end
   end

   assign o_full = r_full;
   assign o_rd   = r_rd;
   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// Module   : reg_writeback
// Purpose  : ALU/load writeback arbiter with pending-write scoreboard and
//            forwarded read ports in front of the general register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback
   import regfile_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   input  logic [IDXW-1:0]           issue_rd,
   output logic                      issue_ready,
   input  logic                      alu_valid,
   input  logic [IDXW-1:0]           alu_rd,
   input  logic [XLEN-1:0]           alu_data,
   output logic                      alu_ready,
   input  logic                      mem_valid,
   input  logic [IDXW-1:0]           mem_rd,
   input  logic [XLEN-1:0]           mem_data,
   output logic                      mem_ready,
   output logic [NREG-1:0][XLEN-1:0] wb_data,
   output logic [NREG-1:0]           wb_en,
   input  logic [NREG-1:0][XLEN-1:0] reg_q,
   input  logic [IDXW-1:0]           rs1_idx,
   input  logic [IDXW-1:0]           rs2_idx,
   output logic [XLEN-1:0]           rs1_data,
   output logic [XLEN-1:0]           rs2_data,
   output logic                      rs1_busy,
   output logic                      rs2_busy
);

   logic            w_skid_full;
   logic [IDXW-1:0] w_skid_rd;
   logic [XLEN-1:0] w_skid_data;
   logic            w_capture;
   logic            w_drain;

   logic            w_alu_src_valid;
   logic [IDXW-1:0] w_alu_src_rd;
   logic [XLEN-1:0] w_alu_src_data;
   logic            w_conflict;
   logic            w_grant_alu;
   logic            w_grant_mem;
   wb_req_t         w_win;

   src_t            r_last_win;
   wb_req_t         r_wb;
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            w_issue_fire;

   wb_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .i_capture (w_capture),
      .i_drain   (w_drain),
      .i_rd      (alu_rd),
      .i_data    (alu_data),
      .o_full    (w_skid_full),
      .o_rd      (w_skid_rd),
      .o_data    (w_skid_data)
   );

   // A held skid entry always takes precedence over the live ALU port.
   always_comb begin
      w_alu_src_valid = w_skid_full | alu_valid;
      w_alu_src_rd    = w_skid_full ? w_skid_rd   : alu_rd;
      w_alu_src_data  = w_skid_full ? w_skid_data : alu_data;
      w_conflict      = w_alu_src_valid & mem_valid;
      w_grant_alu     = w_alu_src_valid & (~mem_valid | (r_last_win == SRC_MEM));
      w_grant_mem     = mem_valid & ~w_grant_alu;
      w_capture       = ~w_skid_full & alu_valid & ~w_grant_alu;
      w_drain         = w_skid_full & w_grant_alu;
      w_win.valid     = w_grant_alu | w_grant_mem;
      w_win.rd        = w_grant_alu ? w_alu_src_rd   : mem_rd;
      w_win.data      = w_grant_alu ? w_alu_src_data : mem_data;
   end

   assign alu_ready = ~w_skid_full;
   assign mem_ready = w_grant_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_win <= SRC_ALU;
      end else if (w_conflict) begin
         r_last_win <= w_grant_alu ? SRC_ALU : SRC_MEM;
      end
   end

   // r0 results complete their handshake but never produce a write enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb <= '0;
      end else begin
         r_wb.valid <= w_win.valid && (w_win.rd != '0);
         if (w_win.valid) begin
            r_wb.rd   <= w_win.rd;
            r_wb.data <= w_win.data;
         end
      end
   end

   generate
      for (genvar i = 0; i < NREG; i++) begin : g_lane
         assign wb_data[i] = r_wb.data;
         assign wb_en[i]   = r_wb.valid && (r_wb.rd == IDXW'(i));
      end
   endgenerate

   assign issue_ready  = ~issue_valid || (issue_rd == '0) || ~r_busy[issue_rd];
   assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

   always_comb begin
      w_busy_nxt = r_busy;
      if (w_win.valid) begin
         w_busy_nxt[w_win.rd] = 1'b0;
      end
      if (w_issue_fire) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // The WB register covers the cycle before the register file holds the value.
   always_comb begin
      rs1_busy = r_busy[rs1_idx] && (rs1_idx != '0);
      rs2_busy = r_busy[rs2_idx] && (rs2_idx != '0);
      if (rs1_idx == '0) begin
         rs1_data = '0;
      end else if (r_wb.valid && (r_wb.rd == rs1_idx)) begin
         rs1_data = r_wb.data;
      end else begin
         rs1_data = reg_q[rs1_idx];
      end
      if (rs2_idx == '0) begin
         rs2_data = '0;
      end else if (r_wb.valid && (r_wb.rd == rs2_idx)) begin
         rs2_data = r_wb.data;
      end else begin
         rs2_data = reg_q[rs2_idx];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// Module   : tb_reg_writeback
// Purpose  : Scoreboard bench for reg_writeback with a behavioural register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback;
   import regfile_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      issue_valid = 1'b0;
   logic [IDXW-1:0]           issue_rd = '0;
   logic                      issue_ready;
   logic                      alu_valid = 1'b0;
   logic [IDXW-1:0]           alu_rd = '0;
   logic [XLEN-1:0]           alu_data = '0;
   logic                      alu_ready;
   logic                      mem_valid = 1'b0;
   logic [IDXW-1:0]           mem_rd = '0;
   logic [XLEN-1:0]           mem_data = '0;
   logic                      mem_ready;
   logic [NREG-1:0][XLEN-1:0] wb_data;
   logic [NREG-1:0]           wb_en;
   logic [NREG-1:0][XLEN-1:0] rf;
   logic [IDXW-1:0]           rs1_idx = '0;
   logic [IDXW-1:0]           rs2_idx = '0;
   logic [XLEN-1:0]           rs1_data;
   logic [XLEN-1:0]           rs2_data;
   logic                      rs1_busy;
   logic                      rs2_busy;

   typedef struct {
      int          rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   reg_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .alu_ready   (alu_ready),
      .mem_valid   (mem_valid),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .mem_ready   (mem_ready),
      .wb_data     (wb_data),
      .wb_en       (wb_en),
      .reg_q       (rf),
      .rs1_idx     (rs1_idx),
      .rs2_idx     (rs2_idx),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy)
   );

   // Register file model, seeded with distinct values so forwarding is visible.
   always @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (rst) rf[i] <= 32'h1000_0000 + i;
         else if (wb_en[i]) rf[i] <= wb_data[i];
      end
   end

   always @(negedge clk) begin
      if (!rst && wb_en != '0) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL wb_unexpected: got wb_en=%h data=%h, expected no write", wb_en, wb_data[0]);
         end else begin
            e = q.pop_front();
            if (wb_en !== (16'h1 << e.rd) || wb_data[e.rd] !== e.data || wb_data[0] !== e.data) begin
               n_err++;
               $display("FAIL wb_write: got en=%h data=%h, expected en=%h data=%h",
                        wb_en, wb_data[e.rd], 16'h1 << e.rd, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int rd);
      issue_valid = 1'b1;
      issue_rd    = IDXW'(rd);
      cyc();
      issue_valid = 1'b0;
   endtask

   initial begin
      rs1_idx = 4'd3;
      repeat (2) cyc();
      @(negedge clk);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_alu_ready", alu_ready, 1);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", rs1_busy, 0);
      chk("post_rst_issue_ready", issue_ready, 1);
      cyc();

      // ALU only
      issue_valid = 1'b1; issue_rd = 4'd3;
      @(negedge clk); chk("issue_rd3_ready", issue_ready, 1);
      cyc(); issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
      q.push_back('{3, 32'hDEADBEEF});
      @(negedge clk); chk("rd3_busy", rs1_busy, 1); chk("alu_ready_idle", alu_ready, 1);
      cyc(); alu_valid = 1'b0;
      @(negedge clk); chk("rd3_busy_clr", rs1_busy, 0); chk("rd3_fwd", rs1_data, 32'hDEADBEEF);
      cyc();
      @(negedge clk); chk("rd3_regq", rs1_data, 32'hDEADBEEF); chk("wb_en_idle", wb_en, 0);
      cyc();

      // Conflict from reset arbitration state: memory wins first
      issue(5); issue(6);
      rs2_idx = 4'd5;
      alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 32'd1;
      mem_valid = 1'b1; mem_rd = 4'd6; mem_data = 32'd2;
      q.push_back('{6, 32'd2}); q.push_back('{5, 32'd1});
      @(negedge clk); chk("cf_mem_ready", mem_ready, 1); chk("cf_alu_ready", alu_ready, 1);
      cyc(); alu_valid = 1'b0; mem_valid = 1'b0;
      @(negedge clk); chk("cf_skid_full", alu_ready, 0); chk("cf_rd5_busy", rs2_busy, 1);
      cyc();
      @(negedge clk); chk("cf_skid_drained", alu_ready, 1);
      cyc();

      // Continuous memory traffic alternating with ALU
      issue(8); issue(9); issue(10); issue(11);
      alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 32'hA8;
      mem_valid = 1'b1; mem_rd = 4'd10; mem_data = 32'hB10;
      q.push_back('{8, 32'hA8});
      @(negedge clk); chk("alt0_mem_ready", mem_ready, 0); chk("alt0_alu_ready", alu_ready, 1);
      cyc();
      alu_rd = 4'd9; alu_data = 32'hA9;
      q.push_back('{10, 32'hB10});
      @(negedge clk); chk("alt1_mem_ready", mem_ready, 1); chk("alt1_alu_ready", alu_ready, 1);
      cyc();
      alu_valid = 1'b0; mem_rd = 4'd11; mem_data = 32'hB11;
      q.push_back('{9, 32'hA9});
      @(negedge clk); chk("alt2_mem_ready", mem_ready, 0); chk("alt2_alu_ready", alu_ready, 0);
      cyc();
      q.push_back('{11, 32'hB11});
      @(negedge clk); chk("alt3_mem_ready", mem_ready, 1);
      cyc(); mem_valid = 1'b0;

      // WAW guard on rd=7
      issue_valid = 1'b1; issue_rd = 4'd7; rs1_idx = 4'd7;
      @(negedge clk); chk("waw_first", issue_ready, 1);
      cyc();
      @(negedge clk); chk("waw_second_blocked", issue_ready, 0);
      cyc();
      alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h77;
      q.push_back('{7, 32'h77});
      @(negedge clk); chk("waw_blocked_at_accept", issue_ready, 0);
      cyc(); alu_valid = 1'b0;
      @(negedge clk); chk("waw_released", issue_ready, 1);
      cyc(); issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 32'h78;
      q.push_back('{7, 32'h78});
      @(negedge clk); chk("waw_rd7_busy", rs1_busy, 1);
      cyc(); alu_valid = 1'b0;
      @(negedge clk); chk("waw_rd7_clr", rs1_busy, 0); chk("waw_rd7_fwd", rs1_data, 32'h78);
      cyc();

      // r0 is never reserved and never written
      issue_valid = 1'b1; issue_rd = 4'd0; rs2_idx = 4'd0;
      @(negedge clk); chk("r0_issue_ready", issue_ready, 1);
      cyc(); issue_valid = 1'b0;
      @(negedge clk); chk("r0_not_busy", rs2_busy, 0);
      alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 32'hFFFF;
      @(negedge clk); chk("r0_alu_ready", alu_ready, 1);
      cyc(); alu_valid = 1'b0; rs1_idx = 4'd0;
      @(negedge clk); chk("r0_wb_en", wb_en, 0); chk("r0_read_zero", rs1_data, 0);
      cyc();

      // Reset with a WB write and a skid entry in flight
      issue(12); issue(13);
      rs1_idx = 4'd12; rs2_idx = 4'd13;
      alu_valid = 1'b1; alu_rd = 4'd12; alu_data = 32'hC12;
      mem_valid = 1'b1; mem_rd = 4'd13; mem_data = 32'hD13;
      cyc();
      alu_valid = 1'b0; mem_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("midrst_wb_en", wb_en, 0); chk("midrst_alu_ready", alu_ready, 1);
      chk("midrst_busy12", rs1_busy, 0);
      cyc(); rst = 1'b0;
      @(negedge clk);
      chk("rel_wb_en", wb_en, 0); chk("rel_alu_ready", alu_ready, 1);
      chk("rel_busy12", rs1_busy, 0); chk("rel_busy13", rs2_busy, 0);
      cyc();

      // Arbitration history restarts at ALU after reset
      issue(14); issue(15);
      alu_valid = 1'b1; alu_rd = 4'd14; alu_data = 32'hE14;
      mem_valid = 1'b1; mem_rd = 4'd15; mem_data = 32'hF15;
      q.push_back('{15, 32'hF15}); q.push_back('{14, 32'hE14});
      @(negedge clk); chk("rcf_mem_ready", mem_ready, 1);
      cyc(); alu_valid = 1'b0; mem_valid = 1'b0;
      @(negedge clk); chk("rcf_skid_full", alu_ready, 0);
      cyc();
      @(negedge clk); chk("rcf_skid_drained", alu_ready, 1);
      repeat (3) cyc();

      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
